// File: rtl/div_unit_pkg.sv
// Shared pipeline types for the divider: word and ALU-function types, divider FSM states
// and iteration count.
package div_unit_pkg;

  typedef logic [63:0] word_t;

  typedef enum logic [3:0] {
    ADD,
    SUB,
    MUL,
    DIV,
    DIVU,
    REM,
    REMU
  } alufunc_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

  localparam int DIV_ITERS = 64;
  localparam int DIV_CNT_W = $clog2(DIV_ITERS);

endpackage

// File: rtl/div_unit_div_step.sv
// One restoring radix-2 iteration: shift the next dividend bit into the partial remainder,
// and subtract the divisor when it fits.
module div_step
  import div_unit_pkg::*;
(
  input  word_t rem_i,
  input  word_t quo_i,
  input  word_t dvsr_i,
  output word_t rem_o,
  output word_t quo_o
);

  logic [64:0] shifted;
  logic        fits;

  assign shifted = {rem_i, quo_i[63]};
  assign fits    = shifted >= {1'b0, dvsr_i};
  // When the divisor fits, the difference is always below 2^64, so the low 64 bits are exact.
  assign rem_o   = fits ? (shifted[63:0] - dvsr_i) : shifted[63:0];
  assign quo_o   = {quo_i[62:0], fits};

endmodule

// File: rtl/div_unit.sv
// Iterative 64-bit divider (DIV/DIVU/REM/REMU plus W forms): fixed 65-cycle latency, with a
// ready/valid handshake on both sides.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and |a|<|b| ops finish in one cycle.
module div_unit
  import div_unit_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     valid_in,
  output logic     ready,
  input  word_t    a,
  input  word_t    b,
  input  alufunc_t func,
  input  logic     is_word,
  input  logic     flush,
  output logic     valid_out,
  input  logic     out_ready,
  output word_t    result,
  output logic     busy
);

  div_state_t             state_q, state_d;
  logic [DIV_CNT_W-1:0]   cnt_q, cnt_d;
  word_t                  rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  word_t                  result_q, result_d;
  logic                   qsign_q, qsign_d, rsign_q, rsign_d;
  logic                   dz_q, dz_d, remsel_q, remsel_d, word_q, word_d;

  logic                   accept, signed_op, rem_op, a_neg, b_neg;
  word_t                  a_abs, b_abs, step_rem, step_quo;

  // Signed min/-1 overflow needs no special case: |a|=2^63 and |b|=1 give q=2^63 with
  // positive sign, which equals a, and a remainder of 0.
  function automatic word_t fixup(word_t qm, word_t rm, logic qs, logic rs, logic dz,
                                  logic rsel, logic w);
    word_t q, r, res;
    q = qs ? word_t'(-qm) : qm;
    r = rs ? word_t'(-rm) : rm;
    if (dz) q = '1;
    res = rsel ? r : q;
    if (w) res = {{32{res[31]}}, res[31:0]};
    return res;
  endfunction

  assign ready     = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign valid_out = (state_q == DONE);
  assign result    = result_q;

  assign accept    = valid_in && ready && !flush;
  assign signed_op = (func == DIV) || (func == REM);
  assign rem_op    = (func == REM) || (func == REMU);
  assign a_neg     = signed_op && a[63];
  assign b_neg     = signed_op && b[63];
  assign a_abs     = a_neg ? word_t'(-a) : a;
  assign b_abs     = b_neg ? word_t'(-b) : b;

  div_step u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    result_d = result_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    dz_d     = dz_q;
    remsel_d = remsel_q;
    word_d   = word_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rem_d    = '0;
          quo_d    = a_abs;
          dvsr_d   = b_abs;
          qsign_d  = a_neg ^ b_neg;
          rsign_d  = a_neg;
          dz_d     = (b == '0);
          remsel_d = rem_op;
          word_d   = is_word;
          cnt_d    = DIV_CNT_W'(DIV_ITERS - 1);
          state_d  = BUSY;
`ifdef DIV_EARLY_OUT_EN
          if ((b == '0) || (a_abs < b_abs)) begin
            cnt_d    = '0;
            state_d  = DONE;
            result_d = fixup('0, a_abs, a_neg ^ b_neg, a_neg, b == '0, rem_op, is_word);
          end
`endif
        end
      end
      BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - DIV_CNT_W'(1);
        if (cnt_q == '0) begin
          state_d  = DONE;
          result_d = fixup(step_quo, step_rem, qsign_q, rsign_q, dz_q, remsel_q, word_q);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      dz_q     <= 1'b0;
      remsel_q <= 1'b0;
      word_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      result_q <= result_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      dz_q     <= dz_d;
      remsel_q <= remsel_d;
      word_q   <= word_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed divide vectors with hand-computed results and
// latencies, plus flush, reset and output back-pressure scenarios.
module tb_div_unit;
  import div_unit_pkg::*;

  typedef struct {
    word_t res;
    int    lat;
    int    acc;
    string name;
  } exp_t;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic     clk = 1'b0;
  logic     reset, valid_in, flush, out_ready, is_word;
  word_t    a, b;
  alufunc_t func;
  logic     ready, valid_out, busy;
  word_t    result;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   handoffs = 0;
  bit   presented = 1'b0;

  div_unit dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready     (ready),
    .a         (a),
    .b         (b),
    .func      (func),
    .is_word   (is_word),
    .flush     (flush),
    .valid_out (valid_out),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_for(bit early);
    return (EARLY && early) ? 1 : 65;
  endfunction

  task automatic chk(string name, word_t got, word_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  // Samples on the falling edge; pops one expectation per handoff.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!valid_out) presented = 1'b0;
      else if (!presented) begin
        presented = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got result %h required no output", result);
        end else begin
          chk({sb[0].name, "_result"}, result, sb[0].res);
          chk({sb[0].name, "_latency"}, 64'(cyc - sb[0].acc + 1), 64'(sb[0].lat));
        end
      end else if (sb.size() != 0) begin
        chk({sb[0].name, "_hold"}, result, sb[0].res);
      end
      if (valid_out && out_ready) begin
        handoffs++;
        presented = 1'b0;
        if (sb.size() != 0) void'(sb.pop_front());
      end
    end
  endtask

  task automatic send(word_t av, word_t bv, alufunc_t f, logic w);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    a = av; b = bv; func = f; is_word = w; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic push_exp(string nm, word_t exp, bit early);
    exp_t e;
    e.res  = exp;
    e.lat  = lat_for(early);
    e.acc  = cyc;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic drain(string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got no handoff required one within 300 cycles", nm);
      sb.delete();
    end
  endtask

  task automatic do_op(string nm, word_t av, word_t bv, alufunc_t f, logic w, word_t exp,
                       bit early);
    send(av, bv, f, w);
    push_exp(nm, exp, early);
    drain(nm);
  endtask

  initial begin
    fork
      monitor();
    join_none

    reset = 1'b1; valid_in = 1'b0; flush = 1'b0; out_ready = 1'b1; is_word = 1'b0;
    a = '0; b = '0; func = DIVU;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_result", result, 64'd0);

    do_op("divu_100_7", 64'd100, 64'd7, DIVU, 1'b0, 64'd14, 1'b0);
    do_op("remu_100_7", 64'd100, 64'd7, REMU, 1'b0, 64'd2, 1'b0);
    do_op("div_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    do_op("rem_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    do_op("div_5_0", 64'd5, 64'd0, DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    do_op("rem_5_0", 64'd5, 64'd0, REM, 1'b0, 64'd5, 1'b1);
    do_op("divu_big_0", 64'h8000_0000_0000_0003, 64'd0, DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    do_op("remu_big_0", 64'h8000_0000_0000_0003, 64'd0, REMU, 1'b0, 64'h8000_0000_0000_0003, 1'b1);
    do_op("div_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, DIV, 1'b0,
          64'h8000_0000_0000_0000, 1'b0);
    do_op("rem_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, REM, 1'b0, 64'd0, 1'b0);
    do_op("divw_ovf", 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, DIV, 1'b1,
          64'hFFFF_FFFF_8000_0000, 1'b0);
    do_op("remw_ovf", 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, REM, 1'b1, 64'd0, 1'b0);
    do_op("divuw", 64'h0000_0000_FFFF_FFFF, 64'd2, DIVU, 1'b1, 64'h0000_0000_7FFF_FFFF, 1'b0);
    do_op("div_small", 64'd3, 64'hFFFF_FFFF_FFFF_FFF6, DIV, 1'b0, 64'd0, 1'b1);
    do_op("rem_small", 64'hFFFF_FFFF_FFFF_FFFD, 64'd10, REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);

    // Flush sampled at accept+10: nothing may ever be presented afterwards.
    send(64'd1000, 64'd3, DIVU, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_valid", 64'(valid_out), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_ready", 64'(ready), 64'd1);
    begin
      bit seen;
      seen = 1'b0;
      repeat (80) begin
        @(posedge clk); #1;
        if (valid_out) seen = 1'b1;
      end
      chk("flush_no_valid", 64'(seen), 64'd0);
    end

    // Reset sampled at accept+20 of a new op.
    send(64'd1000, 64'd3, DIVU, 1'b0);
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("midrst_ready", 64'(ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_valid", 64'(valid_out), 64'd0);
    chk("midrst_result", result, 64'd0);
    repeat (80) @(posedge clk);
    #1;
    chk("midrst_idle", 64'(valid_out), 64'd0);

    // Back-pressure: result must hold for 5 cycles, then exactly one handoff.
    out_ready = 1'b0;
    send(64'd100, 64'd7, DIVU, 1'b0);
    push_exp("stall_divu", 64'd14, 1'b0);
    begin
      int n;
      int h0;
      n = 0;
      while (!valid_out && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      chk("stall_reached_done", 64'(valid_out), 64'd1);
      repeat (5) begin
        @(posedge clk); #1;
        chk("stall_valid", 64'(valid_out), 64'd1);
        chk("stall_result", result, 64'd14);
        chk("stall_ready", 64'(ready), 64'd0);
      end
      h0 = handoffs;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_release_valid", 64'(valid_out), 64'd0);
      chk("stall_handoffs", 64'(handoffs - h0), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("stall_single", 64'(handoffs - h0), 64'd1);
    end
    drain("stall_divu");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
